register_file_structural: RTL and testbench



---
 rtl/register_file_structural.sv | 53 +++++
 tb/tb_register_file_structural.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_structural.sv
// Register file with 15 stored M-bit registers, two combinational read ports
// and one synchronous write port. Read address 2^N-1 returns the external
// R15 (program-counter) value instead of stored state.
module register_file_structural #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         WE3,
    input  logic [N-1:0] A1,
    input  logic [N-1:0] A2,
    input  logic [N-1:0] A3,
    input  logic [M-1:0] WD3,
    input  logic [M-1:0] R15,
    output logic [M-1:0] RD1,
    output logic [M-1:0] RD2
);

    localparam int unsigned NUM_SRC  = 2 ** N;
    localparam int unsigned NUM_REGS = NUM_SRC - 1;

    logic [NUM_REGS-1:0] w_we;
    logic [M-1:0]        r_regs [NUM_REGS];
    logic [M-1:0]        w_src  [NUM_SRC];

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_reg
            // One-hot write decode; the top address has no decoder output, so writes to it vanish
            assign w_we[g] = WE3 && (A3 == N'(g));

            // Enable-gated storage register with asynchronous clear
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_regs[g] <= '0;
                end else if (w_we[g]) begin
                    r_regs[g] <= WD3;
                end
            end

            assign w_src[g] = r_regs[g];
        end
    endgenerate

    // Top mux input is the live R15 value, so every address selects a defined source
    assign w_src[NUM_REGS] = R15;

    // Two independent 16:1 read multiplexers
    assign RD1 = w_src[A1];
    assign RD2 = w_src[A2];

endmodule

// File: tb/tb_register_file_structural.sv
// Randomised and directed checks of register_file_structural against an
// array-based reference model.
module tb_register_file_structural;

    logic        clk;
    logic        reset;
    logic        WE3;
    logic [3:0]  A1;
    logic [3:0]  A2;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic [31:0] R15;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks;
    int failures;
    logic [31:0] model [15];

    register_file_structural #(.N(4), .M(32)) dut (
        .clk   (clk),
        .reset (reset),
        .WE3   (WE3),
        .A1    (A1),
        .A2    (A2),
        .A3    (A3),
        .WD3   (WD3),
        .R15   (R15),
        .RD1   (RD1),
        .RD2   (RD2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] expect_rd(input logic [3:0] a);
        if (a == 4'd15) return R15;
        return model[a];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 15; i++) model[i] = '0;
    endtask

    // Single write cycle; model follows the write rules at the capturing edge
    task automatic do_write(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        WE3 = 1'b1;
        A3  = addr;
        WD3 = data;
        @(posedge clk);
        if (reset && addr != 4'd15) model[addr] = data;
        #1;
        WE3 = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #12;
        for (int i = 0; i < 15; i++) begin
            A1 = 4'(i);
            A2 = 4'(14 - i);
            #1;
            checks++;
            if (RD1 !== 32'h0 || RD2 !== 32'h0) begin
                failures++;
                $display("FAIL reset_sweep addr=%0d rd1=%h rd2=%h expected 0", i, RD1, RD2);
            end
        end
        R15 = 32'h0000_1234;
        A1  = 4'd15;
        #1;
        checks++;
        if (RD1 !== 32'h0000_1234) begin
            failures++;
            $display("FAIL reset_r15 rd1=%h expected 00001234", RD1);
        end
    endtask

    task automatic test_write_readback();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 15; i++) do_write(4'(i), 32'(i + 1));
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            A1 = 4'(k);
            A2 = 4'(14 - k);
            #1;
            checks++;
            if (RD1 !== 32'(k + 1) || RD2 !== 32'(15 - k)) begin
                failures++;
                $display("FAIL readback a1=%0d a2=%0d rd1=%h rd2=%h expected %h %h",
                         k, 14 - k, RD1, RD2, 32'(k + 1), 32'(15 - k));
            end
        end
    endtask

    task automatic test_r15_path();
        @(negedge clk);
        A1  = 4'd15;
        A2  = 4'd15;
        R15 = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (RD1 !== 32'hDEAD_BEEF || RD2 !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL r15_read rd1=%h rd2=%h expected deadbeef", RD1, RD2);
        end
        R15 = 32'h0000_0008;
        #1;
        checks++;
        if (RD1 !== 32'h0000_0008 || RD2 !== 32'h0000_0008) begin
            failures++;
            $display("FAIL r15_follow rd1=%h rd2=%h expected 00000008", RD1, RD2);
        end
        do_write(4'd15, 32'hFFFF_FFFF);
        for (int k = 0; k < 15; k++) begin
            A1 = 4'(k);
            A2 = 4'(k);
            #1;
            checks++;
            if (RD1 !== 32'(k + 1) || RD2 !== 32'(k + 1)) begin
                failures++;
                $display("FAIL r15_write_dropped addr=%0d rd1=%h rd2=%h expected %h",
                         k, RD1, RD2, 32'(k + 1));
            end
        end
    endtask

    task automatic test_write_enable();
        do_write(4'd5, 32'h55);
        @(negedge clk);
        WE3 = 1'b0;
        A3  = 4'd5;
        WD3 = 32'hAA;
        A1  = 4'd5;
        @(posedge clk);
        #1;
        checks++;
        if (RD1 !== 32'h55) begin
            failures++;
            $display("FAIL we_low rd1=%h expected 00000055", RD1);
        end
        @(negedge clk);
        WE3 = 1'b1;
        #1;
        checks++;
        if (RD1 !== 32'h55) begin
            failures++;
            $display("FAIL no_bypass rd1=%h expected 00000055", RD1);
        end
        @(posedge clk);
        #1;
        model[5] = 32'hAA;
        checks++;
        if (RD1 !== 32'hAA) begin
            failures++;
            $display("FAIL write_latency rd1=%h expected 000000aa", RD1);
        end
        WE3 = 1'b0;
    endtask

    task automatic test_async_reset();
        do_write(4'd3, 32'h33);
        @(negedge clk);
        A1 = 4'd3;
        #1;
        checks++;
        if (RD1 !== 32'h33) begin
            failures++;
            $display("FAIL pre_reset rd1=%h expected 00000033", RD1);
        end
        #1;
        reset = 1'b0;
        clear_model();
        #1;
        checks++;
        if (RD1 !== 32'h0) begin
            failures++;
            $display("FAIL async_reset rd1=%h expected 0", RD1);
        end
        @(negedge clk);
        reset = 1'b1;
        do_write(4'd3, 32'h77);
        #1;
        checks++;
        if (RD1 !== 32'h77) begin
            failures++;
            $display("FAIL post_reset_write rd1=%h expected 00000077", RD1);
        end
        // Reset dropping with a write edge: reset must win
        @(negedge clk);
        WE3 = 1'b1;
        A3  = 4'd7;
        WD3 = 32'h1234_5678;
        A1  = 4'd7;
        @(posedge clk);
        reset = 1'b0;
        clear_model();
        #1;
        WE3 = 1'b0;
        checks++;
        if (RD1 !== 32'h0) begin
            failures++;
            $display("FAIL reset_vs_write rd1=%h expected 0", RD1);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            A1  = 4'($urandom_range(0, 15));
            A2  = 4'($urandom_range(0, 15));
            A3  = 4'($urandom_range(0, 15));
            WE3 = 1'($urandom_range(0, 1));
            WD3 = $urandom;
            R15 = $urandom;
            #1;
            checks++;
            if (RD1 !== expect_rd(A1) || RD2 !== expect_rd(A2)) begin
                failures++;
                $display("FAIL rand_pre n=%0d a1=%0d a2=%0d rd1=%h rd2=%h expected %h %h",
                         n, A1, A2, RD1, RD2, expect_rd(A1), expect_rd(A2));
            end
            @(posedge clk);
            if (reset && WE3 && A3 != 4'd15) model[A3] = WD3;
            #1;
            checks++;
            if (RD1 !== expect_rd(A1) || RD2 !== expect_rd(A2)) begin
                failures++;
                $display("FAIL rand_post n=%0d a1=%0d a2=%0d rd1=%h rd2=%h expected %h %h",
                         n, A1, A2, RD1, RD2, expect_rd(A1), expect_rd(A2));
            end
            if ($urandom_range(0, 39) == 0) begin
                #1;
                reset = 1'b0;
                clear_model();
                #1;
                reset = 1'b1;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        WE3      = 1'b0;
        A1       = '0;
        A2       = '0;
        A3       = '0;
        WD3      = '0;
        R15      = '0;
        clear_model();
        test_reset();
        test_write_readback();
        test_r15_path();
        test_write_enable();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
